// File: rtl/fft_sched_pkg.sv
// Shared definitions for the FFT frame scheduler.
//  - sched_state_e : scheduler state encoding
//  - sched_ctl_t   : registered control bundle driven onto the FFT / readout interface
//  - FRAME_LEN, HOLD_TMO, counter widths, frame_len() helper
package fft_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic fft_ce;
        logic fft_din_zero;
        logic fft_out_en;
        logic busy;
        logic frame_done;
    } sched_ctl_t;

    localparam int unsigned SCHED_N   = 9;
    localparam int unsigned FRAME_LEN = 32'(1) << SCHED_N;
    localparam int unsigned HOLD_TMO  = 4;
    localparam int unsigned TMR_W     = 3;
    localparam int unsigned OVF_W     = 16;

    // Frame length for an arbitrary log2 size.
    function automatic int unsigned frame_len(input int unsigned n);
        return 32'(1) << n;
    endfunction

endpackage

// File: rtl/sched_cnt.sv
// Saturating up-counter used for the scheduler's sample, latency and output counts.
//  clk, areset : clock, asynchronous active-low reset
//  en          : count enable (ignored once q reaches SAT)
//  clr         : synchronous clear, priority over en
//  q           : count value
//  term_c      : q == SAT (combinational)
module sched_cnt #(
    parameter int unsigned W   = 10,
    parameter int unsigned SAT = 512
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         term_c
);

    assign term_c = (q == W'(SAT));

    // Count register: clear wins, then saturating increment.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && !term_c) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame sequencer for the 2^N-point pipelined radix-2 FFT: gates ADC samples into the core,
// flushes the pipeline with zeros, strobes outputs to the reorder buffer, then waits for the
// buffer's readout before the next frame.
// Optional build macro SCHED_OVF_EN adds dropped-sample flags ovf / ovf_cnt.
//  clk, areset  : clock, asynchronous active-low reset
//  start        : request one frame (accepted only in IDLE)
//  cont         : re-arm automatically after each frame
//  abort        : return to IDLE next cycle, no frame_done
//  adc_valid    : input sample valid
//  rd_busy      : readout buffer replaying the stored frame
//  fft_ce       : FFT core clock-enable
//  fft_din_zero : force FFT input to zero during flush
//  fft_out_en   : FFT output valid (buffer write enable)
//  cnt_fft      : output index, valid with fft_out_en
//  busy         : not IDLE
//  frame_done   : one-cycle pulse on HOLD exit
//  ovf, ovf_cnt : (SCHED_OVF_EN) sticky flag / saturating count of samples dropped while cont=1
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int unsigned N       = SCHED_N,
    parameter int unsigned FFT_LAT = FRAME_LEN - 1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             adc_valid,
    input  logic             rd_busy,
    output logic             fft_ce,
    output logic             fft_din_zero,
    output logic             fft_out_en,
    output logic [N-1:0]     cnt_fft,
    output logic             busy,
    output logic             frame_done
`ifdef SCHED_OVF_EN
    ,
    output logic             ovf,
    output logic [OVF_W-1:0] ovf_cnt
`endif
);

    localparam int unsigned CW   = N + 1;
    localparam int unsigned FLEN = frame_len(N);

    sched_state_e    state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic            seen_q, seen_d;
    sched_ctl_t      ctl_q, ctl_d;
    logic [N-1:0]    cnt_fft_q, cnt_fft_d;

    logic [CW-1:0]   in_cnt, lat_cnt, out_cnt;
    logic            in_full_c, lat_sat_c, out_full_c;
    logic            ce_c, zero_c, oen_c, in_en_c, clr_c, done_c;
    logic            unused_cnt_c;

    // Samples accepted into the current frame.
    sched_cnt #(.W(CW), .SAT(FLEN)) u_in_cnt (
        .clk    (clk),
        .areset (areset),
        .en     (in_en_c),
        .clr    (clr_c),
        .q      (in_cnt),
        .term_c (in_full_c)
    );

    // fft_ce cycles since the first accepted sample; saturation opens the output window.
    sched_cnt #(.W(CW), .SAT(FFT_LAT)) u_lat_cnt (
        .clk    (clk),
        .areset (areset),
        .en     (ce_c),
        .clr    (clr_c),
        .q      (lat_cnt),
        .term_c (lat_sat_c)
    );

    // Output index.
    sched_cnt #(.W(CW), .SAT(FLEN)) u_out_cnt (
        .clk    (clk),
        .areset (areset),
        .en     (oen_c),
        .clr    (clr_c),
        .q      (out_cnt),
        .term_c (out_full_c)
    );

    // Counter values other than out_cnt are only observed through their flags.
    assign unused_cnt_c = ^{in_cnt, lat_cnt, out_full_c};

    // State and registered outputs.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            seen_q    <= 1'b0;
            ctl_q     <= '0;
            cnt_fft_q <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            seen_q    <= seen_d;
            ctl_q     <= ctl_d;
            cnt_fft_q <= cnt_fft_d;
        end
    end

    // Next state, counter controls and next registered outputs.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        seen_d    = seen_q;
        ctl_d     = '0;
        cnt_fft_d = '0;
        ce_c      = 1'b0;
        zero_c    = 1'b0;
        oen_c     = 1'b0;
        in_en_c   = 1'b0;
        clr_c     = 1'b0;
        done_c    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clr_c   = 1'b1;
                end
            end
            ST_RUN: begin
                // Feed while fewer than 2^N samples are in, then clock zeros through.
                zero_c  = in_full_c;
                ce_c    = in_full_c ? 1'b1 : adc_valid;
                in_en_c = ce_c & ~in_full_c;
                oen_c   = ce_c & lat_sat_c;
                if (oen_c && out_cnt == CW'(FLEN - 1)) begin
                    state_d = ST_HOLD;
                    tmr_d   = '0;
                    seen_d  = 1'b0;
                end
            end
            ST_HOLD: begin
                // Readout done after a busy high->low, or if busy never rose in time.
                if (rd_busy) begin
                    seen_d = 1'b1;
                end
                if (tmr_q != TMR_W'(HOLD_TMO)) begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
                if (!rd_busy && (seen_q || tmr_q == TMR_W'(HOLD_TMO))) begin
                    done_c  = 1'b1;
                    clr_c   = 1'b1;
                    state_d = cont ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                clr_c   = 1'b1;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            clr_c   = 1'b1;
            ce_c    = 1'b0;
            zero_c  = 1'b0;
            oen_c   = 1'b0;
            in_en_c = 1'b0;
            done_c  = 1'b0;
        end

        ctl_d.fft_ce       = ce_c;
        ctl_d.fft_din_zero = zero_c;
        ctl_d.fft_out_en   = oen_c;
        ctl_d.busy         = (state_d != ST_IDLE);
        ctl_d.frame_done   = done_c;
        cnt_fft_d          = oen_c ? out_cnt[N-1:0] : '0;
    end

    assign fft_ce       = ctl_q.fft_ce;
    assign fft_din_zero = ctl_q.fft_din_zero;
    assign fft_out_en   = ctl_q.fft_out_en;
    assign busy         = ctl_q.busy;
    assign frame_done   = ctl_q.frame_done;
    assign cnt_fft      = cnt_fft_q;

`ifdef SCHED_OVF_EN
    logic             ovf_q;
    logic [OVF_W-1:0] ovf_cnt_q;
    logic             ovf_hit_c, start_acc_c;

    assign ovf_hit_c   = adc_valid && cont && (state_q == ST_HOLD || state_q == ST_IDLE);
    assign start_acc_c = start && !abort && (state_q == ST_IDLE);

    // Dropped-sample tracking; an accepted start clears it.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (start_acc_c) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
        end else if (ovf_hit_c) begin
            ovf_q <= 1'b1;
            if (ovf_cnt_q != '1) begin
                ovf_cnt_q <= ovf_cnt_q + OVF_W'(1);
            end
        end
    end

    assign ovf     = ovf_q;
    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed self-checking bench for fft_frame_sched (N=9, FFT_LAT=511).
module tb_fft_frame_sched;

    localparam int unsigned N = 9;

    logic         clk = 1'b0;
    logic         areset;
    logic         start, cont, abort, adc_valid, rd_busy;
    logic         fft_ce, fft_din_zero, fft_out_en, busy, frame_done;
    logic [N-1:0] cnt_fft;
`ifdef SCHED_OVF_EN
    logic         ovf;
    logic [15:0]  ovf_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fft_frame_sched #(.N(N), .FFT_LAT(511)) dut (
        .clk          (clk),
        .areset       (areset),
        .start        (start),
        .cont         (cont),
        .abort        (abort),
        .adc_valid    (adc_valid),
        .rd_busy      (rd_busy),
        .fft_ce       (fft_ce),
        .fft_din_zero (fft_din_zero),
        .fft_out_en   (fft_out_en),
        .cnt_fft      (cnt_fft),
        .busy         (busy),
        .frame_done   (frame_done)
`ifdef SCHED_OVF_EN
        ,
        .ovf          (ovf),
        .ovf_cnt      (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame from start (or from an auto re-arm) to frame_done.
    // duty: adc_valid every duty-th cycle. busy_len: rd_busy cycles raised after the last
    // output (0 = never). hold_valid: adc_valid cycles driven during HOLD.
    task automatic run_frame(input string tag, input bit do_start, input int duty,
                             input int busy_len, input int hold_valid, input int exp_done);
        int   first_ce = -1, last_out = -1, n_feed = 0, n_ce = 0, ce_pre = -1, out_gap = -1;
        int   n_out = 0, seq_err = 0, bad = 0, busy_low = 0, done_off = -1, h;
        bit   zero_seen = 1'b0, got_done = 1'b0;
        logic busy_done = 1'b0;
        start     = do_start;
        adc_valid = 1'b0;
        rd_busy   = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            if (frame_done) begin
                got_done  = 1'b1;
                done_off  = cyc - last_out;
                busy_done = busy;
                break;
            end
            if (!busy) busy_low++;
            if (last_out >= 0 && (fft_ce || fft_out_en)) bad++;
            if (fft_din_zero) begin
                zero_seen = 1'b1;
                if (!fft_ce) bad++;
            end
            if (fft_ce && !fft_din_zero) begin
                n_feed++;
                if (zero_seen) bad++;
            end
            if (fft_out_en) begin
                if (!fft_ce) bad++;
                if (n_out == 0) begin
                    ce_pre  = n_ce;
                    out_gap = cyc - first_ce;
                end
                if (int'(cnt_fft) != n_out) seq_err++;
                n_out++;
                if (n_out == 512) last_out = cyc;
            end
            if (fft_ce) begin
                if (first_ce < 0) first_ce = cyc;
                n_ce++;
            end
            // A start while busy must be ignored.
            start = (cyc == 100);
            if (last_out < 0) begin
                adc_valid = ((cyc % duty) == 0);
            end else begin
                h         = cyc - last_out;
                rd_busy   = (h < busy_len);
                adc_valid = (h < hold_valid);
            end
        end
        start     = 1'b0;
        adc_valid = 1'b0;
        rd_busy   = 1'b0;
        check_eq({tag, "_done"}, 32'(got_done), 32'd1);
        check_eq({tag, "_nfeed"}, n_feed, 512);
        check_eq({tag, "_lat"}, ce_pre, 511);
        if (duty == 1) check_eq({tag, "_gap"}, out_gap, 511);
        check_eq({tag, "_nout"}, n_out, 512);
        check_eq({tag, "_seq"}, seq_err, 0);
        check_eq({tag, "_proto"}, bad, 0);
        check_eq({tag, "_busy"}, busy_low, 0);
        check_eq({tag, "_doneoff"}, done_off, exp_done);
        check_eq({tag, "_busydone"}, 32'(busy_done), 32'(cont));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dones;
        areset    = 1'b0;
        start     = 1'b0;
        cont      = 1'b0;
        abort     = 1'b0;
        adc_valid = 1'b0;
        rd_busy   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctl", {27'd0, fft_ce, fft_din_zero, fft_out_en, busy, frame_done}, 32'd0);
        check_eq("rst_cnt", 32'(cnt_fft), 32'd0);
        areset = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Continuous samples, no readout: timeout ends HOLD 4 cycles after its first cycle.
        run_frame("t1", 1'b1, 1, 0, 0, 5);
        // Half-rate samples.
        run_frame("t2", 1'b1, 2, 0, 0, 5);
        // Slow readout: frame_done one cycle after rd_busy falls.
        run_frame("t3", 1'b1, 1, 100, 0, 101);
        // Auto re-arm, then cont dropped during the second frame.
        cont = 1'b1;
        run_frame("t4a", 1'b1, 1, 0, 0, 5);
        cont = 1'b0;
        run_frame("t4b", 1'b0, 1, 0, 0, 5);
        @(negedge clk);
        check_eq("t4_idle", 32'(busy), 32'd0);

        // Abort at output index 200.
        start     = 1'b1;
        adc_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(fft_out_en && cnt_fft == 9'd200) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_reach", 32'(n < 2000), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t5_oen", 32'(fft_out_en), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_ce", 32'(fft_ce), 32'd0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            dones += int'(frame_done);
        end
        check_eq("t5_nodone", dones, 0);
        // start together with abort: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_eq("t5_sa_busy", 32'(busy), 32'd0);
        run_frame("t5c", 1'b1, 1, 0, 0, 5);

        // Asynchronous reset mid-frame.
        start     = 1'b1;
        adc_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        check_eq("rst_mid_pre", 32'(fft_ce), 32'd1);
        areset = 1'b0;
        #1;
        check_eq("rst_mid_ctl", {27'd0, fft_ce, fft_din_zero, fft_out_en, busy, frame_done}, 32'd0);
        @(negedge clk);
        areset = 1'b1;
        run_frame("t_rst", 1'b1, 1, 0, 0, 5);

`ifdef SCHED_OVF_EN
        // Ten samples arrive during HOLD with cont=1.
        cont = 1'b1;
        run_frame("t6", 1'b1, 1, 30, 10, 31);
        check_eq("t6_ovf", 32'(ovf), 32'd1);
        check_eq("t6_ovf_cnt", 32'(ovf_cnt), 32'd10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        cont  = 1'b0;
        check_eq("t6_keep", 32'(ovf_cnt), 32'd10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("t6_clr_ovf", 32'(ovf), 32'd0);
        check_eq("t6_clr_cnt", 32'(ovf_cnt), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
